uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_sync.sv | 25 ++
 rtl/uart_tx.sv | 90 +++++++++
 rtl/uart_rx.sv | 117 +++++++++++
 tb/tb_uart_rx.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver and transmitter.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 434;  // 50 MHz clock, 115200 baud
    localparam int DATA_BITS            = 8;

    // Frame-level FSM states; the transmitter uses the subset it needs.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        RECOVER = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line (resets to idle-high).
module uart_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic sync_reg;

    // Two back-to-back flops; both reset high so a reset never looks like a start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
        end else begin
            meta_reg <= d;
            sync_reg <= meta_reg;
        end
    end

    assign q = sync_reg;

endmodule

// File: rtl/uart_tx.sv
// 8N1 serial transmitter; a new frame can be launched from IDLE with a one-cycle start.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_state_e          state_reg;
    logic [CW-1:0]        cnt_reg;
    logic [BW-1:0]        bit_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 tx_reg;

    // Each line level is held for exactly CLKS_PER_BIT cycles; data goes out LSB first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (start) begin
                        shift_reg <= data_in;
                        tx_reg    <= 1'b0;
                        state_reg <= START;
                    end
                end
                START: begin
                    if (cnt_reg == LAST_CNT) begin
                        cnt_reg   <= '0;
                        bit_reg   <= '0;
                        tx_reg    <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        state_reg <= DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_reg == LAST_CNT) begin
                        cnt_reg <= '0;
                        if (bit_reg == LAST_BIT) begin
                            tx_reg    <= 1'b1;
                            state_reg <= STOP;
                        end else begin
                            bit_reg   <= bit_reg + BW'(1);
                            tx_reg    <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_reg == LAST_CNT) begin
                        cnt_reg   <= '0;
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: begin
                    tx_reg    <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign tx   = tx_reg;
    assign busy = (state_reg != IDLE);

endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with mid-bit sampling, glitch rejection and break recovery.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int DATA_BITS    = uart_pkg::DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_CNT = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 rx_s;
    uart_state_e          state_reg;
    logic [CW-1:0]        cnt_reg;
    logic [BW-1:0]        bit_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] data_reg;
    logic                 valid_reg;
    logic                 ferr_reg;

    uart_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Frame FSM: half a bit into the start bit to centre, then one full bit per sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            bit_reg   <= '0;
            shift_reg <= '0;
            data_reg  <= '0;
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            ferr_reg  <= 1'b0;
            case (state_reg)
                IDLE: begin
                    cnt_reg <= '0;
                    if (!rx_s) begin
                        state_reg <= START;
                    end
                end
                START: begin
                    if (cnt_reg == HALF_CNT) begin
                        cnt_reg   <= '0;
                        bit_reg   <= '0;
                        // A line already back high at mid-start is a glitch, not a frame.
                        state_reg <= rx_s ? IDLE : DATA;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_reg == LAST_CNT) begin
                        cnt_reg   <= '0;
                        shift_reg <= {rx_s, shift_reg[DATA_BITS-1:1]};
                        if (bit_reg == LAST_BIT) begin
                            state_reg <= STOP;
                        end else begin
                            bit_reg <= bit_reg + BW'(1);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_reg == LAST_CNT) begin
                        cnt_reg <= '0;
                        if (rx_s) begin
                            data_reg  <= shift_reg;
                            valid_reg <= 1'b1;
                            state_reg <= IDLE;
                        end else begin
                            ferr_reg  <= 1'b1;
                            state_reg <= RECOVER;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                RECOVER: begin
                    // Wait out a break; only a return to idle-high re-arms start detection.
                    cnt_reg <= '0;
                    if (rx_s) begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    cnt_reg   <= '0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign data_out  = data_reg;
    assign valid     = valid_reg;
    assign frame_err = ferr_reg;
    assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx, driven by a looped-back uart_tx or by hand-built frames.
module tb_uart_rx;
    import uart_pkg::*;

    localparam int CPB = 16;
    localparam int DB  = 8;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          rx;
    logic [DB-1:0] data_out;
    logic          valid;
    logic          frame_err;
    logic          busy;

    logic          tx_start  = 1'b0;
    logic [DB-1:0] tx_data   = '0;
    logic          tx_line;
    logic          tx_busy;
    logic          man_en    = 1'b0;
    logic          man_rx    = 1'b1;

    int            vectors     = 0;
    int            miscompares = 0;
    logic [DB-1:0] exp_q[$];
    int            err_q[$];
    logic [DB-1:0] last_good   = '0;
    logic          valid_prev  = 1'b0;
    logic          ferr_prev   = 1'b0;

    always #10 clk = ~clk;

    assign rx = man_en ? man_rx : tx_line;

    uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) u_tx (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (tx_start),
        .data_in (tx_data),
        .tx      (tx_line),
        .busy    (tx_busy)
    );

    uart_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .data_out  (data_out),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h at %0t", tag, obs, $time);
        end
    endtask

    task automatic send_byte(input logic [DB-1:0] b, input bit push);
        int n;
        n = 0;
        while (tx_busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (push) exp_q.push_back(b);
        tx_data  = b;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic drive_bit(input logic v);
        man_rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, exp_q.size() + err_q.size(), 0);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, busy, 1'b0);
    endtask

    // Output monitor: pops the scoreboard on every pulse and checks pulse shape.
    always @(negedge clk) begin
        if (valid || frame_err) check("pulse_exclusive", valid & frame_err, 1'b0);
        if (valid) begin
            check("valid_width", valid_prev, 1'b0);
            if (exp_q.size() == 0) begin
                check("unexpected_valid", valid, 1'b0);
            end else begin
                logic [DB-1:0] e;
                e = exp_q.pop_front();
                check("rx_data", data_out, e);
                last_good = e;
            end
        end
        if (frame_err) begin
            check("ferr_width", ferr_prev, 1'b0);
            if (err_q.size() == 0) begin
                check("unexpected_ferr", frame_err, 1'b0);
            end else begin
                void'(err_q.pop_front());
                check("ferr_data_hold", data_out, last_good);
            end
        end
        valid_prev = valid;
        ferr_prev  = frame_err;
    end

    initial begin
        logic [DB-1:0] frame_byte;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_data_out", data_out, 0);
        check("rst_valid", valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_busy", busy, 1'b0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single byte through the transmitter
        send_byte(8'hAA, 1'b1);
        wait_drain("aa_drain", 400);
        repeat (20) @(negedge clk);

        // Back-to-back frames
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h5A, 1'b1);
        wait_drain("b2b_drain", 900);
        repeat (20) @(negedge clk);

        // Short low glitch must be rejected
        man_en = 1'b1;
        man_rx = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_busy_set", busy, 1'b1);
        man_rx = 1'b1;
        wait_idle("glitch_busy_clear", 8);
        repeat (20) @(negedge clk);

        // Stop bit low, line held in break for three further bit periods
        frame_byte = 8'h3C;
        err_q.push_back(1);
        drive_bit(1'b0);
        for (int i = 0; i < DB; i++) drive_bit(frame_byte[i]);
        for (int k = 0; k < 4; k++) begin
            drive_bit(1'b0);
            check("break_busy", busy, 1'b1);
        end
        man_rx = 1'b1;
        wait_idle("break_busy_clear", 8);
        wait_drain("break_drain", 10);
        check("break_data_hold", data_out, last_good);
        repeat (20) @(negedge clk);
        man_en = 1'b0;
        repeat (5) @(negedge clk);

        // Reset during data bit 4 aborts the frame
        send_byte(8'hC3, 1'b0);
        repeat (CPB * 5 + CPB / 2 + 3) @(negedge clk);
        check("abort_busy_before", busy, 1'b1);
        rst_n     = 1'b0;
        last_good = '0;
        @(negedge clk);
        check("abort_rst_data_out", data_out, 0);
        check("abort_rst_valid", valid, 1'b0);
        check("abort_rst_frame_err", frame_err, 1'b0);
        check("abort_rst_busy", busy, 1'b0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_byte(8'h81, 1'b1);
        wait_drain("post_reset_drain", 400);
        repeat (50) @(negedge clk);
        check("post_reset_hold", data_out, last_good);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
